// File: rtl/j_chunk_streamer.sv
// j_chunk_streamer: fetches the J-matrix column chunks from SRAM and streams them to MatMul in order
module j_chunk_streamer #(
   parameter int MEM_BANDWIDTH    = 16384,
   parameter int VECTOR_SIZE      = 256,
   parameter int J_ELEMENT_WIDTH  = 4,
   parameter int J_COLS_PER_READ  = MEM_BANDWIDTH / (VECTOR_SIZE * J_ELEMENT_WIDTH),
   parameter int NUM_J_CHUNKS     = VECTOR_SIZE / J_COLS_PER_READ,
   parameter int MEM_ADDR_WIDTH   = 16,
   parameter int MEM_READ_LATENCY = 1,
   parameter int FIFO_DEPTH       = MEM_READ_LATENCY + 1
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic [MEM_ADDR_WIDTH-1:0]         base_addr,
   output logic                              busy,
   output logic                              done,
   output logic                              mem_req,
   output logic [MEM_ADDR_WIDTH-1:0]         mem_addr,
   input  logic [MEM_BANDWIDTH-1:0]          mem_rdata,
   output logic                              chunk_valid,
   input  logic                              chunk_ready,
   output logic [J_ELEMENT_WIDTH-1:0]        J_Matrix_chunk [0:VECTOR_SIZE-1][0:J_COLS_PER_READ-1],
   output logic [$clog2(NUM_J_CHUNKS)-1:0]   chunk_idx,
   output logic                              chunk_last
);
   localparam int IW = $clog2(NUM_J_CHUNKS) + 1;
   localparam int XW = $clog2(NUM_J_CHUNKS);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int FW = $clog2(MEM_READ_LATENCY + 2);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
   state_t state, state_nx;

   logic [MEM_ADDR_WIDTH-1:0]   base_q;
   logic [IW-1:0]               issue_cnt;
   logic [XW-1:0]               ret_cnt;
   logic [MEM_READ_LATENCY-1:0] tag;
   logic [FW-1:0]               in_flight;
   logic [MEM_BANDWIDTH-1:0]    fifo_data [FIFO_DEPTH];
   logic [XW-1:0]               fifo_idx  [FIFO_DEPTH];
   logic [PW-1:0]               wr_ptr, rd_ptr;
   logic [CW-1:0]               occ;
   logic                        accept, pop, push;
   int                          credit;

   assign push = tag[MEM_READ_LATENCY-1];

   // issue credit, pass completion and next state
   always_comb begin
      credit   = int'(occ) + int'(in_flight);
      pop      = chunk_valid && chunk_ready;
      mem_req  = state == FETCH && issue_cnt < IW'(NUM_J_CHUNKS) &&
                 (credit < FIFO_DEPTH || (credit == FIFO_DEPTH && pop));
      mem_addr = mem_req ? base_q + MEM_ADDR_WIDTH'(issue_cnt) : '0;
      done     = state == DRAIN && occ == '0 && in_flight == '0;
      accept   = start && (state == IDLE || done);
      state_nx = accept ? FETCH : done ? IDLE :
                 (state == FETCH && issue_cnt == IW'(NUM_J_CHUNKS)) ? DRAIN : state;
   end

   // state register
   always_ff @(posedge clk) state <= rst ? IDLE : state_nx;

   // counters, return tags and FIFO pointers; reset drops reads still in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         base_q    <= '0;
         issue_cnt <= '0;
         ret_cnt   <= '0;
         tag       <= '0;
         in_flight <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occ       <= '0;
      end else begin
         if (accept) begin
            base_q    <= base_addr;
            issue_cnt <= '0;
            ret_cnt   <= '0;
         end else begin
            if (mem_req) issue_cnt <= issue_cnt + 1'b1;
            if (push) ret_cnt <= ret_cnt + 1'b1;
         end
         tag       <= MEM_READ_LATENCY'({tag, mem_req});
         in_flight <= in_flight + FW'(mem_req) - FW'(push);
         if (push) wr_ptr <= wr_ptr == PW'(FIFO_DEPTH - 1) ? '0 : wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr == PW'(FIFO_DEPTH - 1) ? '0 : rd_ptr + 1'b1;
         occ <= occ + CW'(push) - CW'(pop);
      end
   end

   // return buffer storage, tagged with the chunk index in arrival order
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= mem_rdata;
         fifo_idx[wr_ptr]  <= ret_cnt;
      end
   end

   // a write into a full buffer without a simultaneous pop would lose a chunk
   always_ff @(posedge clk) begin
      if (!rst && push && !pop) assert (int'(occ) < FIFO_DEPTH);
   end

   // present the buffer head; outputs read as zero while nothing is buffered
   always_comb begin
      chunk_valid = occ != '0;
      busy        = state != IDLE;
      chunk_idx   = chunk_valid ? fifo_idx[rd_ptr] : '0;
      chunk_last  = chunk_valid && (&fifo_idx[rd_ptr]);
      for (int r = 0; r < VECTOR_SIZE; r++)
         for (int c = 0; c < J_COLS_PER_READ; c++)
            J_Matrix_chunk[r][c] = chunk_valid ?
               fifo_data[rd_ptr][(c*VECTOR_SIZE + r)*J_ELEMENT_WIDTH +: J_ELEMENT_WIDTH] : '0;
   end
endmodule

// File: tb/tb_j_chunk_streamer.sv
// tb_j_chunk_streamer: scoreboard bench for the J-chunk streamer against a J-matrix level model
module tb_j_chunk_streamer;
   localparam int VS = 8, EW = 4, MB = 64, CPR = 2, NC = 4, AW = 16, LAT = 2;

   logic clk = 0, rst, start, chunk_ready;
   logic busy, done, mem_req, chunk_valid, chunk_last;
   logic [AW-1:0] base_addr, mem_addr;
   logic [MB-1:0] mem_rdata;
   logic [EW-1:0] J_Matrix_chunk [0:VS-1][0:CPR-1];
   logic [1:0] chunk_idx;

   typedef struct packed {
      logic [15:0] pid;
      logic [1:0]  idx;
      logic        last;
      logic [VS-1:0][CPR-1:0][EW-1:0] el;
   } chunk_t;

   chunk_t exp_q[$];
   logic [AW-1:0] addr_q[$];
   logic [MB-1:0] mem [65536];
   logic [MB-1:0] rpipe [LAT];
   int tests = 0, fails = 0, done_cnt = 0, pass_cnt = 0;
   logic [15:0] next_pid = 0, expect_pid = 0, last_pid = 16'hFFFF;
   logic last_last = 0;

   j_chunk_streamer #(
      .MEM_BANDWIDTH(MB), .VECTOR_SIZE(VS), .J_ELEMENT_WIDTH(EW),
      .MEM_ADDR_WIDTH(AW), .MEM_READ_LATENCY(LAT)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .busy(busy), .done(done),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
      .chunk_valid(chunk_valid), .chunk_ready(chunk_ready), .J_Matrix_chunk(J_Matrix_chunk),
      .chunk_idx(chunk_idx), .chunk_last(chunk_last)
   );

   always #5 clk = ~clk;

   // fixed-latency SRAM; garbage on the bus whenever no read is returning
   always @(posedge clk) begin
      for (int i = LAT - 1; i > 0; i--) rpipe[i] <= rpipe[i-1];
      rpipe[0] <= mem_req ? mem[mem_addr] : {$urandom, $urandom};
   end
   assign mem_rdata = rpipe[LAT-1];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", nm, act, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic chunk_t head();
      chunk_t h;
      h = '0;
      h.idx = chunk_idx;
      h.last = chunk_last;
      for (int r = 0; r < VS; r++)
         for (int c = 0; c < CPR; c++) h.el[r][c] = J_Matrix_chunk[r][c];
      return h;
   endfunction

   // build a J matrix, store it column-chunk-wise in memory, queue the expected stream, pulse start
   task automatic start_pass(input logic [AW-1:0] base, input bit fixed);
      logic [EW-1:0] j [VS][VS];
      logic [MB-1:0] w;
      chunk_t e;
      for (int r = 0; r < VS; r++)
         for (int col = 0; col < VS; col++) j[r][col] = fixed ? EW'(col / CPR) : EW'($urandom);
      for (int k = 0; k < NC; k++) begin
         w = '0;
         e = '0;
         e.pid = next_pid;
         e.idx = 2'(k);
         e.last = k == NC - 1;
         for (int r = 0; r < VS; r++)
            for (int c = 0; c < CPR; c++) begin
               w[(c*VS + r)*EW +: EW] = j[r][k*CPR + c];
               e.el[r][c] = j[r][k*CPR + c];
            end
         mem[AW'(base + AW'(k))] = w;
         addr_q.push_back(AW'(base + AW'(k)));
         exp_q.push_back(e);
      end
      next_pid++;
      pass_cnt++;
      base_addr = base;
      start = 1;
   endtask

   // monitor: addresses, handshaken chunks, hold stability and done placement
   initial begin
      chunk_t cur, held, e;
      logic [AW-1:0] a;
      bit hold;
      hold = 0;
      held = '0;
      forever begin
         @(negedge clk);
         cur = head();
         if (rst) hold = 0;
         else begin
            if (hold) begin
               chk("hold_valid", chunk_valid, 1);
               chk("hold_stable", cur, held);
            end
            if (mem_req) begin
               if (addr_q.size() == 0) chk("extra_req", mem_addr, 64'hFFFF_FFFF);
               else begin
                  a = addr_q.pop_front();
                  chk("addr", mem_addr, a);
               end
            end
            if (chunk_valid && chunk_ready) begin
               if (exp_q.size() == 0) chk("extra_chunk", chunk_idx, 64'hFFFF_FFFF);
               else begin
                  e = exp_q.pop_front();
                  chk("idx", chunk_idx, e.idx);
                  chk("last", chunk_last, e.last);
                  chk("data", cur.el, e.el);
                  last_pid = e.pid;
                  last_last = e.last;
               end
            end
            if (done) begin
               chk("done_pass", {last_pid, last_last}, {expect_pid, 1'b1});
               expect_pid++;
               done_cnt++;
            end
            hold = chunk_valid && !chunk_ready;
            held = cur;
         end
      end
   end

   initial begin
      int nreq, dcyc, dn, nlate, remaining, guard;
      bit got;
      rst = 1;
      start = 0;
      chunk_ready = 1;
      base_addr = '0;
      tick();
      tick();
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_req", mem_req, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_valid", chunk_valid, 0);
      chk("rst_idx", chunk_idx, 0);
      chk("rst_last", chunk_last, 0);
      chk("rst_data", head().el, 0);
      tick();
      rst = 0;
      tick();

      // streaming with ready held high; expected cycles follow from the latency rules
      start_pass(16'h0010, 1);
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk($sformatf("req@%0d", c), mem_req, c >= 1 && c <= NC);
         chk($sformatf("valid@%0d", c), chunk_valid, c >= 2 + LAT && c <= 1 + LAT + NC);
         chk($sformatf("last@%0d", c), chunk_last, c == 1 + LAT + NC);
         chk($sformatf("done@%0d", c), done, c == 2 + LAT + NC);
         chk($sformatf("busy@%0d", c), busy, c >= 1 && c <= 2 + LAT + NC);
         tick();
         start = 0;
      end

      // backpressure in cycles 4..9: only FIFO_DEPTH reads may be outstanding or buffered
      start_pass(AW'($urandom), 0);
      nreq = 0;
      dcyc = -1;
      for (int c = 0; c < 24; c++) begin
         if (c == 1) start = 0;
         chunk_ready = !(c >= 4 && c <= 9);
         @(negedge clk);
         if (c <= 9 && mem_req) nreq++;
         if (c == 9) chk("bp_req_count", 64'(nreq), LAT + 1);
         if (done) dcyc = c;
         tick();
      end
      chunk_ready = 1;
      chk("bp_done_cycle", 64'(dcyc), 14);

      // address wrap, with a start during busy that must be ignored
      start_pass(16'hFFFE, 0);
      dn = 0;
      nlate = 0;
      for (int c = 0; c < 16; c++) begin
         if (c == 1 || c == 4) start = 0;
         if (c == 3) begin
            start = 1;
            base_addr = 16'h1234;
         end
         @(negedge clk);
         if (done) dn++;
         if (c > 2 + LAT + NC && (mem_req || busy)) nlate++;
         tick();
      end
      chk("wrap_dones", 64'(dn), 1);
      chk("wrap_no_second_pass", 64'(nlate), 0);

      // reset mid-pass: returning data must be dropped
      start_pass(AW'($urandom), 0);
      for (int c = 0; c < 10; c++) begin
         if (c == 1) start = 0;
         chunk_ready = c < 5;
         if (c == 5) begin
            rst = 1;
            exp_q.delete();
            addr_q.delete();
            pass_cnt--;
            expect_pid = next_pid;
         end
         if (c == 6) rst = 0;
         @(negedge clk);
         if (c >= 6) begin
            chk($sformatf("mid_rst_busy@%0d", c), busy, 0);
            chk($sformatf("mid_rst_req@%0d", c), mem_req, 0);
            chk($sformatf("mid_rst_valid@%0d", c), chunk_valid, 0);
            chk($sformatf("mid_rst_done@%0d", c), done, 0);
            chk($sformatf("mid_rst_idx@%0d", c), chunk_idx, 0);
            chk($sformatf("mid_rst_data@%0d", c), head().el, 0);
         end
         tick();
      end
      chunk_ready = 1;
      start_pass(AW'($urandom), 0);
      got = 0;
      for (int c = 0; c < 30 && !got; c++) begin
         if (c == 1) start = 0;
         @(negedge clk);
         got = done;
         tick();
      end
      start = 0;
      chk("fresh_done", got, 1);

      // random ready, random bases, sometimes restarting in the done cycle
      start_pass(AW'($urandom), 0);
      remaining = 200;
      guard = 0;
      while (remaining > 0 && guard < 20000) begin
         tick();
         guard++;
         start = 0;
         chunk_ready = 1'($urandom_range(0, 1));
         if (done) begin
            remaining--;
            if (remaining > 0 && $urandom_range(0, 1) == 1) start_pass(AW'($urandom), 0);
         end else if (!busy && remaining > 0) start_pass(AW'($urandom), 0);
      end
      start = 0;
      chunk_ready = 1;
      repeat (4) tick();
      chk("rand_passes_left", 64'(remaining), 0);
      chk("done_total", 64'(done_cnt), 64'(pass_cnt));
      chk("chunks_left", 64'(exp_q.size()), 0);
      chk("addrs_left", 64'(addr_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
